// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives the program counter controls, issues one
// instruction-memory request at a time and buffers each response for decode.
module fetch_sequencer #(
  parameter int              AW         = 5,
  parameter int              DW         = 32,
  parameter logic [AW-1:0]   RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pc_ce,
  output logic          pc_wr,
  output logic [AW-1:0] pc_addrin,
  input  logic [AW-1:0] pc_addr,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  input  logic          br_valid,
  input  logic [AW-1:0] br_target,
  input  logic          stall,
  output logic          if_valid,
  output logic [DW-1:0] if_instr,
  output logic [AW-1:0] if_pc,
  input  logic          if_ready
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_DRAIN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_if_valid;
  logic [DW-1:0] r_if_instr;
  logic [AW-1:0] r_if_pc;
  logic [AW-1:0] r_req_pc;

  logic w_can_issue;
  logic w_redirect;
  logic w_grant;
  logic w_fill;

  assign imem_addr = pc_addr;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;

  always_comb begin
    w_next      = r_state;
    pc_ce       = 1'b0;
    pc_wr       = 1'b0;
    pc_addrin   = '0;
    imem_req    = 1'b0;
    w_redirect  = 1'b0;
    w_grant     = 1'b0;
    w_fill      = 1'b0;
    w_can_issue = !r_if_valid || if_ready;
    if (!rst) begin
      case (r_state)
        S_BOOT: begin
          pc_ce     = 1'b1;
          pc_wr     = 1'b1;
          pc_addrin = RESET_ADDR;
          w_next    = S_FETCH;
        end
        S_FETCH: begin
          if (br_valid) begin
            w_redirect = 1'b1;
          end else begin
            imem_req = w_can_issue && !stall;
            if (w_can_issue && !stall && imem_gnt) begin
              w_grant = 1'b1;
              pc_ce   = 1'b1;
              w_next  = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (br_valid) begin
            w_redirect = 1'b1;
            w_next     = imem_rvalid ? S_FETCH : S_DRAIN;
          end else if (imem_rvalid) begin
            w_fill = 1'b1;
            w_next = S_FETCH;
          end
        end
        S_DRAIN: begin
          // The stale response ends the drain even if another redirect lands with it.
          if (br_valid)    w_redirect = 1'b1;
          if (imem_rvalid) w_next     = S_FETCH;
        end
        default: w_next = S_BOOT;
      endcase
      if (w_redirect) begin
        pc_ce     = 1'b1;
        pc_wr     = 1'b1;
        pc_addrin = br_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
      r_req_pc   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) r_req_pc <= pc_addr;
      if (w_redirect) begin
        r_if_valid <= 1'b0;
      end else if (w_fill) begin
        r_if_valid <= 1'b1;
        r_if_instr <= imem_rdata;
        r_if_pc    <= r_req_pc;
      end else if (if_ready) begin
        r_if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a directed cycle table followed by randomized
// traffic scored against an in-order fetch-stream model.
module tb_fetch_sequencer;

  localparam int            AW    = 5;
  localparam int            DW    = 32;
  localparam logic [AW-1:0] RST_A = 5'h00;

  logic          clk = 1'b0;
  logic          rst;
  logic          pc_ce, pc_wr;
  logic [AW-1:0] pc_addrin, pc_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt, imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic          stall;
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          if_ready;

  always #5 clk = ~clk;

  fetch_sequencer #(.AW(AW), .DW(DW), .RESET_ADDR(RST_A)) dut (
    .clk(clk), .rst(rst),
    .pc_ce(pc_ce), .pc_wr(pc_wr), .pc_addrin(pc_addrin), .pc_addr(pc_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .br_valid(br_valid), .br_target(br_target), .stall(stall),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready)
  );

  int checks = 0;
  int errors = 0;

  // environment state: program counter register and memory responder
  logic          c_ce, c_wr, c_grant, prev_rst;
  logic [AW-1:0] c_addrin, c_gaddr, last_gnt, pend_addr, exp_pc;
  logic          pend_valid;
  int            pend_cnt;
  int            delivered;

  typedef struct {
    logic rst, gnt, rv, rdy, br; logic [AW-1:0] tgt; logic stl;
    logic ce, wr; logic [AW-1:0] ain; logic req; logic [AW-1:0] ia;
    logic vld; logic [AW-1:0] ipc;
  } vec_t;
  vec_t tv[$];

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return DW'(a) * 32'h0101_0101;
  endfunction

  function automatic vec_t mk(input int r, g, rv, rdy, br, tgt, stl,
                              ce, wr, ain, req, ia, vld, ipc);
    vec_t m;
    m.rst = r[0];   m.gnt = g[0];  m.rv = rv[0]; m.rdy = rdy[0]; m.br = br[0];
    m.tgt = tgt[AW-1:0]; m.stl = stl[0];
    m.ce = ce[0];   m.wr = wr[0];  m.ain = ain[AW-1:0]; m.req = req[0];
    m.ia = ia[AW-1:0]; m.vld = vld[0]; m.ipc = ipc[AW-1:0];
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic capture();
    c_ce     = pc_ce;
    c_wr     = pc_wr;
    c_addrin = pc_addrin;
    c_grant  = imem_req & imem_gnt;
    c_gaddr  = imem_addr;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    if (c_ce) pc_addr = c_wr ? c_addrin : pc_addr + 1'b1;
    if (c_grant) last_gnt = c_gaddr;
    if (rst || imem_rvalid) pend_valid = 1'b0;
    else if (pend_valid && pend_cnt > 0) pend_cnt--;
    if (c_grant) begin
      pend_valid = 1'b1;
      pend_addr  = c_gaddr;
      pend_cnt   = $urandom_range(2, 0);
    end
    prev_rst = rst;
  endtask

  task automatic rcycle(input logic force_rst);
    logic boot;
    rst         = force_rst | ($urandom_range(199, 0) == 0);
    br_valid    = ($urandom_range(11, 0) == 0);
    br_target   = AW'($urandom);
    stall       = ($urandom_range(4, 0) == 0);
    if_ready    = ($urandom_range(9, 0) < 7);
    imem_gnt    = ($urandom_range(9, 0) < 6);
    imem_rvalid = pend_valid && (pend_cnt == 0);
    imem_rdata  = imem_rvalid ? mem(pend_addr) : DW'($urandom);
    @(negedge clk);
    boot = prev_rst && !rst;
    if (rst) begin
      chk("rst_ctl", 32'({pc_ce, pc_wr, imem_req}), 32'd0);
      exp_pc = RST_A;
    end else begin
      chk("pc_ce", 32'(pc_ce), 32'(boot | (imem_req & imem_gnt) | br_valid));
      chk("imem_addr", 32'(imem_addr), 32'(pc_addr));
      if (boot) begin
        chk("boot_load", 32'({pc_wr, pc_addrin}), 32'({1'b1, RST_A}));
        chk("boot_clr", 32'({if_valid, if_pc}), 32'd0);
        chk("boot_instr", if_instr, 32'd0);
      end else if (br_valid) begin
        chk("br_load", 32'({pc_wr, pc_addrin, imem_req}), 32'({1'b1, br_target, 1'b0}));
      end
      if (stall)      chk("stall_req", 32'(imem_req), 32'd0);
      if (pend_valid) chk("one_outstanding", 32'(imem_req), 32'd0);
      if (!boot && !br_valid && if_valid && if_ready) begin
        chk("stream_pc", 32'(if_pc), 32'(exp_pc));
        chk("stream_data", if_instr, mem(if_pc));
        exp_pc = if_pc + 1'b1;
        delivered++;
      end
      if (!boot && br_valid) exp_pc = br_target;
    end
    capture();
    commit();
  endtask

  initial begin
    pc_addr = 5'h0B; last_gnt = '0; pend_valid = 1'b0; pend_addr = '0; pend_cnt = 0;
    prev_rst = 1'b1; exp_pc = RST_A; delivered = 0;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    br_valid = 1'b0; br_target = '0; stall = 1'b0; if_ready = 1'b1;

    //            rst g rv rdy br tgt   stl  ce wr ain   req ia    vld ipc
    tv.push_back(mk(1, 0, 0, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h00));
    tv.push_back(mk(0, 0, 0, 1, 1, 'h07, 0,  1, 1, 'h00, 0, 'h00, 0, 'h00));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h00, 0, 'h00));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h00));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h01, 1, 'h00));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h00));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h02, 1, 'h01));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h01));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h03, 1, 'h02));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h02));
    tv.push_back(mk(0, 0, 0, 1, 1, 'h1E, 0,  1, 1, 'h1E, 0, 'h00, 1, 'h03));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h1E, 0, 'h03));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h03));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h1F, 1, 'h1E));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h1E));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h00, 1, 'h1F));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h1F));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h01, 1, 'h00));
    tv.push_back(mk(0, 0, 1, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h00));
    tv.push_back(mk(0, 1, 0, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 1, 'h01));
    tv.push_back(mk(0, 1, 0, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 1, 'h01));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h02, 1, 'h01));
    tv.push_back(mk(0, 0, 0, 0, 1, 'h10, 0,  1, 1, 'h10, 0, 'h00, 0, 'h01));
    tv.push_back(mk(0, 0, 1, 0, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h01));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h10, 0, 'h01));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h01));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h11, 1, 'h10));
    tv.push_back(mk(0, 0, 1, 1, 1, 'h05, 0,  1, 1, 'h05, 0, 'h00, 0, 'h10));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h05, 0, 'h10));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h10));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 1,  0, 0, 'h00, 0, 'h00, 1, 'h05));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 1,  0, 0, 'h00, 0, 'h00, 0, 'h05));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 1,  0, 0, 'h00, 0, 'h00, 0, 'h05));
    tv.push_back(mk(0, 1, 0, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h06, 0, 'h05));
    tv.push_back(mk(1, 0, 0, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h05));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  1, 1, 'h00, 0, 'h00, 0, 'h00));
    tv.push_back(mk(0, 1, 1, 1, 0, 'h00, 0,  1, 0, 'h00, 1, 'h00, 0, 'h00));
    tv.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 0, 'h00, 0, 'h00, 0, 'h00));
    tv.push_back(mk(0, 0, 0, 1, 0, 'h00, 0,  0, 0, 'h00, 1, 'h01, 1, 'h00));
    tv.push_back(mk(0, 0, 0, 1, 0, 'h00, 0,  0, 0, 'h00, 1, 'h01, 0, 'h00));

    @(negedge clk);
    capture();
    commit();

    foreach (tv[i]) begin
      rst = tv[i].rst; imem_gnt = tv[i].gnt; imem_rvalid = tv[i].rv;
      imem_rdata = mem(last_gnt); if_ready = tv[i].rdy; br_valid = tv[i].br;
      br_target = tv[i].tgt; stall = tv[i].stl;
      @(negedge clk);
      chk($sformatf("v%0d_pc_ce", i), 32'(pc_ce), 32'(tv[i].ce));
      chk($sformatf("v%0d_pc_wr", i), 32'(pc_wr), 32'(tv[i].wr));
      chk($sformatf("v%0d_pc_addrin", i), 32'(pc_addrin), 32'(tv[i].ain));
      chk($sformatf("v%0d_imem_req", i), 32'(imem_req), 32'(tv[i].req));
      if (tv[i].req) chk($sformatf("v%0d_imem_addr", i), 32'(imem_addr), 32'(tv[i].ia));
      chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(tv[i].vld));
      chk($sformatf("v%0d_if_pc", i), 32'(if_pc), 32'(tv[i].ipc));
      chk($sformatf("v%0d_if_instr", i), if_instr, mem(tv[i].ipc));
      capture();
      commit();
    end

    rcycle(1'b1);
    rcycle(1'b1);
    for (int n = 0; n < 3000; n++) rcycle(1'b0);
    chk("stream_progress", 32'(delivered >= 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
